proc_mc: RTL and testbench

Parametrised multicycle processor core, the next generation of the team's 16-bit bus-based `proc`. It has an N-bit datapath, eight registers (R7 = PC), an explicit state machine and a memory port with a ready handshake for wait-state memories. It adds AND and SRA ALU ops and a zero flag for MVNZ. It sits between the instruction/data memory and the board-level I/O, with a Run/Done handshake to the testbench or sequencer.

---
 rtl/proc_pkg.sv | 40 ++++
 rtl/alu_n.sv | 32 +++
 rtl/proc_mc.sv | 152 +++++++++++++++
 tb/tb_proc_mc.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared encodings for the multicycle core: opcodes, FSM states and ALU selects.
package proc_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_AND  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_ST   = 4'b1000;
   localparam logic [3:0] OP_LD   = 4'b1001;
   localparam logic [3:0] OP_MVNZ = 4'b1100;
   localparam logic [3:0] OP_MV   = 4'b1110;
   localparam logic [3:0] OP_MVI  = 4'b1111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_MEM    = 3'd5
   } state_e;

   // ALU select is the low three opcode bits of the ALU group
   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SLT, ALU_SRA
   } alu_op_e;

   function automatic logic is_alu(input logic [3:0] op);
      return op[3] == 1'b0;
   endfunction

   function automatic logic is_mem(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_ST) || (op == OP_MVI);
   endfunction

endpackage

// File: rtl/alu_n.sv
// Combinational N-bit ALU; shift amount comes from the low log2(N) bits of b.
module alu_n
   import proc_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  alu_op_e      op,
   output logic [N-1:0] y
);
   localparam int SW = $clog2(N);

   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_OR:  y = a | b;
         ALU_AND: y = a & b;
         ALU_SLL: y = a << sh;
         ALU_SRL: y = a >> sh;
         ALU_SLT: y = {{(N-1){1'b0}}, (a < b)};
         ALU_SRA: y = $unsigned($signed(a) >>> sh);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/proc_mc.sv
// Multicycle N-bit core: 8 registers (R7 = PC), ready-handshaked memory port,
// Run/Done sequencing. Done is decoded from state so it lines up with mem_ready.
module proc_mc
   import proc_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         Run,
   input  logic [N-1:0] DIN,
   input  logic         mem_ready,
   output logic         mem_req,
   output logic         W,
   output logic [N-1:0] Daddress,
   output logic [N-1:0] DOUT,
   output logic         Done,
   output logic [N-1:0] R7,
   output logic [2:0]   state
);
   state_e            cur;
   logic [7:0][N-1:0] regs;
   logic [N-1:0]      ir, a, g, alu_y, rx, ry, wr_data, pc_next;
   logic [3:0]        opc;
   logic [2:0]        x, y;
   logic              z, wr_en, pc_inc, fin;
   logic              unused_ir;

   assign opc       = ir[N-1 -: 4];
   assign x         = ir[N-5 -: 3];
   assign y         = ir[N-8 -: 3];
   assign unused_ir = ^ir[N-11:0];
   assign rx        = regs[x];
   assign ry        = regs[y];
   assign R7        = regs[7];
   assign state     = cur;
   assign Done      = fin;

   alu_n #(.N(N)) u_alu (
      .a  (a),
      .b  (ry),
      .op (alu_op_e'(opc[2:0])),
      .y  (alu_y)
   );

   // single write port; an explicit R7 write beats the PC increment
   always_comb begin
      wr_en   = 1'b0;
      wr_data = '0;
      pc_inc  = 1'b0;
      fin     = 1'b0;
      case (cur)
         S_FETCH: pc_inc = mem_ready;
         S_DECODE: begin
            if (opc == OP_MV || (opc == OP_MVNZ && !z)) begin
               wr_en   = 1'b1;
               wr_data = ry;
            end
            fin = !is_alu(opc) && !is_mem(opc);
         end
         S_WB: begin
            wr_en   = 1'b1;
            wr_data = g;
            fin     = 1'b1;
         end
         S_MEM: begin
            if (mem_ready) begin
               fin     = 1'b1;
               wr_en   = (opc != OP_ST);
               wr_data = DIN;
               pc_inc  = (opc == OP_MVI);
            end
         end
         default: ;
      endcase
      if (wr_en && x == 3'd7)
         pc_next = wr_data;
      else if (pc_inc)
         pc_next = regs[7] + N'(1);
      else
         pc_next = regs[7];
   end

   always_ff @(posedge Clock) begin
      if (Resetn) begin
         cur      <= S_IDLE;
         regs     <= '0;
         ir       <= '0;
         a        <= '0;
         g        <= '0;
         z        <= 1'b1;
         Daddress <= '0;
         DOUT     <= '0;
         mem_req  <= 1'b0;
         W        <= 1'b0;
      end else begin
         for (int i = 0; i < 7; i++)
            if (wr_en && x == 3'(i)) regs[i] <= wr_data;
         regs[7] <= pc_next;

         case (cur)
            S_IDLE: begin
               if (Run) begin
                  cur      <= S_FETCH;
                  mem_req  <= 1'b1;
                  W        <= 1'b0;
                  Daddress <= regs[7];
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  ir      <= DIN;
                  mem_req <= 1'b0;
                  cur     <= S_DECODE;
               end
            end
            S_DECODE: begin
               a <= rx;
               if (is_alu(opc)) begin
                  cur <= S_EXEC;
               end else if (is_mem(opc)) begin
                  cur      <= S_MEM;
                  mem_req  <= 1'b1;
                  W        <= (opc == OP_ST);
                  Daddress <= (opc == OP_MVI) ? regs[7] : ry;
                  if (opc != OP_MVI) DOUT <= rx;
               end
            end
            S_EXEC: begin
               g   <= alu_y;
               cur <= S_WB;
            end
            S_WB: z <= (g == '0);
            default: ;
         endcase

         // instruction end: chain straight into the next fetch or park in IDLE
         if (fin) begin
            W <= 1'b0;
            if (Run) begin
               cur      <= S_FETCH;
               mem_req  <= 1'b1;
               Daddress <= pc_next;
            end else begin
               cur     <= S_IDLE;
               mem_req <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_proc_mc.sv
// Program-driven bench for proc_mc: stores are checked against a scoreboard,
// plus hand sequences for timing, stalls, PC writes and mid-request reset.
module tb_proc_mc;
   localparam int N = 16;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } sb_t;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b1;
   logic          Run = 1'b0;
   logic [N-1:0]  DIN;
   logic          mem_ready = 1'b1;
   logic          mem_req, W, Done;
   logic [N-1:0]  Daddress, DOUT, R7;
   logic [2:0]    state_o;

   logic [15:0]   mem [256];
   int            stall_cfg = 0;

   // monitor-owned observations
   int            cyc = 0, done_cnt = 0, obs_cnt = 0, wcnt = 0;
   int            stall_obs = 0, stab_err = 0;
   int            done_cyc [64];
   logic [15:0]   done_pc  [64];
   logic [15:0]   obs_addr [64];
   logic [15:0]   obs_data [64];
   logic          prev_stall = 1'b0;
   logic [15:0]   p_addr, p_dout;

   int            npass = 0, ntot = 0, c0 = 0;
   sb_t           exp_q [$];
   vec_t          vt [12];

   always #5 Clock = ~Clock;

   assign DIN = mem[Daddress[7:0]];

   proc_mc #(.N(N)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .Run       (Run),
      .DIN       (DIN),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .W         (W),
      .Daddress  (Daddress),
      .DOUT      (DOUT),
      .Done      (Done),
      .R7        (R7),
      .state     (state_o)
   );

   // memory side: drive ready (stalling stores), then log Done and store commits
   always @(negedge Clock) begin
      if (prev_stall && (!(mem_req && W) || Daddress != p_addr || DOUT != p_dout))
         stab_err++;
      if (mem_req && W) begin
         mem_ready = (wcnt >= stall_cfg);
         wcnt++;
      end else begin
         mem_ready = 1'b1;
         wcnt = 0;
      end
      prev_stall = mem_req && W && !mem_ready;
      p_addr = Daddress;
      p_dout = DOUT;
      #1;
      if (Resetn) begin
         cyc = 0; done_cnt = 0; obs_cnt = 0; stall_obs = 0; stab_err = 0;
      end else begin
         cyc++;
         if (prev_stall) stall_obs++;
         if (Done && done_cnt < 64) begin
            done_cyc[done_cnt] = cyc;
            done_pc[done_cnt]  = R7;
            done_cnt++;
         end
         if (mem_req && W && mem_ready && obs_cnt < 64) begin
            obs_addr[obs_cnt] = Daddress;
            obs_data[obs_cnt] = DOUT;
            obs_cnt++;
         end
      end
   end

   function automatic logic [15:0] enc(input logic [3:0] op, input int xr, input int yr);
      return {op, 3'(xr), 3'(yr), 6'd0};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      @(negedge Clock);
      Resetn = 1'b1;
      Run = 1'b0;
      repeat (2) @(negedge Clock);
      Resetn = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 16'hA000;
   endtask

   task automatic start();
      @(negedge Clock);
      Run = 1'b1;
      #2;
      c0 = cyc;
   endtask

   task automatic wait_stores(input int n);
      for (int i = 0; i < 500 && obs_cnt < n; i++) @(negedge Clock);
   endtask

   task automatic stop(input string nm);
      @(negedge Clock);
      Run = 1'b0;
      for (int i = 0; i < 60 && state_o != 3'd0; i++) @(negedge Clock);
      #2;
      chk({nm, "_idle"}, 32'(state_o), 32'd0);
   endtask

   task automatic check_stores(input string nm);
      int k;
      k = 0;
      chk({nm, "_nstore"}, 32'(obs_cnt), 32'(exp_q.size()));
      while (exp_q.size() > 0) begin
         sb_t e;
         e = exp_q.pop_front();
         chk({nm, "_addr"}, 32'(obs_addr[k]), 32'(e.addr));
         chk({nm, "_data"}, 32'(obs_data[k]), 32'(e.data));
         k++;
      end
   endtask

   initial begin
      vt[0]  = '{4'h0, 16'hFFFF, 16'h0002, 16'h0001};
      vt[1]  = '{4'h1, 16'h0003, 16'h0005, 16'hFFFE};
      vt[2]  = '{4'h1, 16'h1234, 16'h1234, 16'h0000};
      vt[3]  = '{4'h2, 16'h0F0F, 16'h00F0, 16'h0FFF};
      vt[4]  = '{4'h3, 16'h0F0F, 16'h00FF, 16'h000F};
      vt[5]  = '{4'h4, 16'h0001, 16'h0013, 16'h0008};
      vt[6]  = '{4'h4, 16'hFFFF, 16'h000F, 16'h8000};
      vt[7]  = '{4'h5, 16'h8000, 16'h0004, 16'h0800};
      vt[8]  = '{4'h7, 16'h8000, 16'h0004, 16'hF800};
      vt[9]  = '{4'h7, 16'h4000, 16'h0001, 16'h2000};
      vt[10] = '{4'h6, 16'h0003, 16'h0007, 16'h0001};
      vt[11] = '{4'h6, 16'h8000, 16'h0001, 16'h0000};

      clear_mem();
      do_reset();
      @(negedge Clock);
      #2;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_ctl", {29'd0, mem_req, W, Done}, 32'd0);
      chk("rst_addr", 32'(Daddress), 32'd0);
      chk("rst_dout", 32'(DOUT), 32'd0);
      chk("rst_pc", 32'(R7), 32'd0);

      // ALU table: result stored to 0x80, MVNZ R3,R6 result stored to 0x81
      for (int v = 0; v < 12; v++) begin
         do_reset();
         clear_mem();
         mem[0]  = enc(4'hF, 3, 0);  mem[1]  = 16'h5A5A;
         mem[2]  = enc(4'hF, 5, 0);  mem[3]  = vt[v].a;
         mem[4]  = enc(4'hF, 6, 0);  mem[5]  = vt[v].b;
         mem[6]  = enc(vt[v].op, 5, 6);
         mem[7]  = enc(4'hC, 3, 6);
         mem[8]  = enc(4'hF, 4, 0);  mem[9]  = 16'h0080;
         mem[10] = enc(4'h8, 5, 4);
         mem[11] = enc(4'hF, 4, 0);  mem[12] = 16'h0081;
         mem[13] = enc(4'h8, 3, 4);
         exp_q.push_back('{16'h0080, vt[v].res});
         exp_q.push_back('{16'h0081, (vt[v].res != 16'h0) ? vt[v].b : 16'h5A5A});
         start();
         wait_stores(2);
         stop($sformatf("alu%0d", v));
         check_stores($sformatf("alu%0d", v));
      end

      // MVI, MVI, ADD latency and PC, then Z=0 lets MVNZ move
      do_reset();
      clear_mem();
      mem[0] = enc(4'hF, 0, 0);  mem[1] = 16'd5;
      mem[2] = enc(4'hF, 1, 0);  mem[3] = 16'd3;
      mem[4] = enc(4'h0, 0, 1);
      mem[5] = enc(4'hF, 4, 0);  mem[6] = 16'h0090;
      mem[7] = enc(4'h8, 0, 4);
      mem[8] = enc(4'hC, 2, 1);
      mem[9] = enc(4'hF, 4, 0);  mem[10] = 16'h0091;
      mem[11] = enc(4'h8, 2, 4);
      exp_q.push_back('{16'h0090, 16'd8});
      exp_q.push_back('{16'h0091, 16'd3});
      start();
      wait_stores(2);
      chk("seq_done0", 32'(done_cyc[0] - c0), 32'd3);
      chk("seq_done1", 32'(done_cyc[1] - c0), 32'd6);
      chk("seq_done2", 32'(done_cyc[2] - c0), 32'd10);
      chk("seq_pc", 32'(done_pc[2]), 32'd5);
      stop("seq");
      check_stores("seq");

      // stalled stores and a load in between
      do_reset();
      clear_mem();
      stall_cfg = 3;
      mem[0] = enc(4'hF, 4, 0);  mem[1] = 16'h0040;
      mem[2] = enc(4'hF, 1, 0);  mem[3] = 16'h00AA;
      mem[4] = enc(4'h8, 1, 4);
      mem[5] = enc(4'hF, 2, 0);  mem[6] = 16'h0050;
      mem[7] = enc(4'h9, 1, 2);
      mem[8] = enc(4'hF, 4, 0);  mem[9] = 16'h00A0;
      mem[10] = enc(4'h8, 1, 4);
      mem[16'h50] = 16'hBEEF;
      exp_q.push_back('{16'h0040, 16'h00AA});
      exp_q.push_back('{16'h00A0, 16'hBEEF});
      start();
      wait_stores(2);
      chk("stall_done", 32'(done_cyc[2] - c0), 32'd12);
      stop("stall");
      chk("stall_cycles", 32'(stall_obs), 32'd6);
      chk("stall_stable", 32'(stab_err), 32'd0);
      check_stores("stall");
      stall_cfg = 0;

      // MVI R7 redirects the next fetch
      do_reset();
      clear_mem();
      mem[0] = enc(4'hF, 7, 0);     mem[1] = 16'h0010;
      mem[16'h10] = enc(4'hF, 4, 0); mem[16'h11] = 16'h00B0;
      mem[16'h12] = enc(4'h8, 4, 4);
      exp_q.push_back('{16'h00B0, 16'h00B0});
      start();
      for (int i = 0; i < 50 && done_cnt < 1; i++) begin
         @(negedge Clock);
         #2;
      end
      @(negedge Clock);
      #2;
      chk("jmp_state", 32'(state_o), 32'd1);
      chk("jmp_addr", 32'(Daddress), 32'h10);
      chk("jmp_pc", 32'(R7), 32'h10);
      wait_stores(1);
      stop("jmp");
      check_stores("jmp");

      // reset lands in the MEM cycle of a load
      do_reset();
      clear_mem();
      mem[0] = enc(4'hF, 2, 0);  mem[1] = 16'h0050;
      mem[2] = enc(4'h9, 1, 2);
      mem[16'h50] = 16'h1357;
      start();
      for (int i = 0; i < 50 && !(state_o == 3'd5 && Daddress == 16'h0050); i++) begin
         @(negedge Clock);
         #2;
      end
      chk("ldrst_inmem", 32'(state_o), 32'd5);
      Resetn = 1'b1;
      Run = 1'b0;
      @(negedge Clock);
      #2;
      chk("ldrst_state", 32'(state_o), 32'd0);
      chk("ldrst_ctl", {29'd0, mem_req, W, Done}, 32'd0);
      chk("ldrst_addr", 32'(Daddress), 32'd0);
      chk("ldrst_pc", 32'(R7), 32'd0);
      Resetn = 1'b0;
      repeat (2) @(negedge Clock);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
